// File: rtl/iseq_dispatcher_mc.sv
// Multi-channel instruction-sequence dispatcher: pops FWFT FIFOs into one-entry
// ready/valid stages per channel, with masking, abort/flush and a saturating counter.
module iseq_dispatcher_mc #(
    parameter int NUM_CH      = 2,
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          process_iseq,
    input  logic                          abort,
    input  logic [NUM_CH-1:0]             ch_mask,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic [NUM_CH-1:0]             fifo_rd,
    input  logic [NUM_CH-1:0]             fifo_empty,
    input  logic [NUM_CH*INSTR_WIDTH-1:0] fifo_data,
    output logic [NUM_CH-1:0]             disp_en,
    output logic [NUM_CH*INSTR_WIDTH-1:0] disp_instr,
    input  logic [NUM_CH-1:0]             disp_ack,
    output logic [CNT_WIDTH-1:0]          disp_count,
    output logic [1:0]                    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int SW = CNT_WIDTH + 4;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Stage handshake: disp_en is valid; a word is consumed on the cycle disp_ack is
    // high while disp_en is high; disp_en never drops before that cycle.
    state_t                          state_q, state_d;
    logic [NUM_CH-1:0]               mask_q, mask_d;
    logic [NUM_CH-1:0]               valid_q, valid_d;
    logic [NUM_CH*INSTR_WIDTH-1:0]   data_q, data_d;
    logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
    logic                            aborted_q, aborted_d;

    logic [NUM_CH-1:0] stage_ready;
    logic [NUM_CH-1:0] accepted;
    logic [NUM_CH-1:0] load;
    logic              run_complete;
    logic              flush_complete;
    logic [3:0]        acc_cnt;
    logic [SW-1:0]     sum;

    always_comb begin
        stage_ready    = ~valid_q | disp_ack;
        accepted       = valid_q & disp_ack;
        run_complete   = &((~mask_q | fifo_empty) & stage_ready);
        flush_complete = &(fifo_empty & stage_ready);

        fifo_rd = '0;
        case (state_q)
            S_RUN:   fifo_rd = mask_q & ~fifo_empty & stage_ready;
            S_FLUSH: fifo_rd = ~fifo_empty;
            default: fifo_rd = '0;
        endcase
        load = (state_q == S_RUN) ? fifo_rd : '0;
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (process_iseq) begin
                    state_d = S_RUN;
                    mask_d  = ch_mask;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_FLUSH;
                end else if (run_complete) begin
                    state_d = S_DONE;
                end
            end
            S_FLUSH: begin
                if (flush_complete) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Simultaneous ack and load keeps the stage full, giving one word per cycle.
    always_comb begin
        valid_d = load | (valid_q & ~disp_ack);
        data_d  = data_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load[i]) begin
                data_d[i*INSTR_WIDTH +: INSTR_WIDTH] = fifo_data[i*INSTR_WIDTH +: INSTR_WIDTH];
            end
        end
    end

    always_comb begin
        acc_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_cnt = acc_cnt + {3'b000, accepted[i]};
        end
        sum   = {4'b0000, cnt_q} + {{CNT_WIDTH{1'b0}}, acc_cnt};
        cnt_d = cnt_q;
        if (state_q == S_IDLE && process_iseq) begin
            cnt_d = '0;
        end else if (state_q == S_RUN || state_q == S_FLUSH) begin
            cnt_d = (sum > {4'b0000, CNT_MAX}) ? CNT_MAX : sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mask_q    <= '1;
            valid_q   <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy       = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done       = (state_q == S_DONE);
    assign aborted    = aborted_q;
    assign disp_en    = valid_q;
    assign disp_instr = data_q;
    assign disp_count = cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_iseq_dispatcher_mc.sv
// Directed bench for iseq_dispatcher_mc: queue-backed FWFT FIFO model, per-scenario
// tasks with hand-computed cycle expectations, and a narrow-counter instance for saturation.
module tb_iseq_dispatcher_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        process_iseq;
    logic        abort;
    logic [1:0]  ch_mask;
    logic        busy, done, aborted;
    logic [1:0]  fifo_rd;
    logic [1:0]  fifo_empty = 2'b11;
    logic [63:0] fifo_data = 64'h0;
    logic [1:0]  disp_en;
    logic [63:0] disp_instr;
    logic [1:0]  disp_ack;
    logic [15:0] disp_count;
    logic [1:0]  dbg_state;

    logic        s_busy, s_done, s_aborted;
    logic [1:0]  s_fifo_rd, s_disp_en, s_dbg_state;
    logic [63:0] s_disp_instr;
    logic [2:0]  s_disp_count;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] h0, h1;

    int total = 0;
    int bad   = 0;

    iseq_dispatcher_mc #(.NUM_CH(2), .INSTR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .process_iseq(process_iseq), .abort(abort), .ch_mask(ch_mask),
        .busy(busy), .done(done), .aborted(aborted), .fifo_rd(fifo_rd),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .disp_en(disp_en),
        .disp_instr(disp_instr), .disp_ack(disp_ack), .disp_count(disp_count),
        .dbg_state(dbg_state)
    );

    iseq_dispatcher_mc #(.NUM_CH(2), .INSTR_WIDTH(32), .CNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst(rst), .process_iseq(process_iseq), .abort(abort), .ch_mask(ch_mask),
        .busy(s_busy), .done(s_done), .aborted(s_aborted), .fifo_rd(s_fifo_rd),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .disp_en(s_disp_en),
        .disp_instr(s_disp_instr), .disp_ack(disp_ack), .disp_count(s_disp_count),
        .dbg_state(s_dbg_state)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model: pop on the edge where fifo_rd is high, head/empty update after it.
    always @(posedge clk) begin
        if (fifo_rd[0] && q0.size() > 0) void'(q0.pop_front());
        if (fifo_rd[1] && q1.size() > 0) void'(q1.pop_front());
        h0 = (q0.size() > 0) ? q0[0] : 32'h0;
        h1 = (q1.size() > 0) ? q1[0] : 32'h0;
        fifo_empty <= {q1.size() == 0, q0.size() == 0};
        fifo_data  <= {h1, h0};
    end

    task automatic load_fifos(input int n0, input int n1, input logic [31:0] b0, input logic [31:0] b1);
        q0.delete();
        q1.delete();
        for (int i = 0; i < n0; i++) q0.push_back(b0 + 32'(i));
        for (int i = 0; i < n1; i++) q1.push_back(b1 + 32'(i));
        @(posedge clk);
    endtask

    // Leaves the caller at the negedge of cycle 1 (first cycle in RUN).
    task automatic start_seq(input logic [1:0] m);
        @(negedge clk);
        ch_mask      = m;
        process_iseq = 1'b1;
        @(negedge clk);
        process_iseq = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; process_iseq = 1'b0; abort = 1'b0; ch_mask = 2'b00; disp_ack = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({busy, done, aborted, fifo_rd, disp_en} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=0000000", {busy, done, aborted, fifo_rd, disp_en});
        end
        total++;
        if (disp_instr !== 64'h0 || disp_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_data got instr=%h count=%0d exp 0/0", disp_instr, disp_count);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL idle_abort got busy=%b state=%0d exp busy=0 state=0", busy, dbg_state);
        end
    endtask

    task automatic test_basic;
        logic [6:0] exp_ctl;
        logic [1:0] erd, een;
        load_fifos(3, 2, 32'h100, 32'h200);
        disp_ack = 2'b11;
        start_seq(2'b11);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            erd = {c <= 2, c <= 3};
            een = {c >= 2 && c <= 3, c >= 2 && c <= 4};
            exp_ctl = {c <= 4, c == 5, 1'b0, erd, een};
            total++;
            if ({busy, done, aborted, fifo_rd, disp_en} !== exp_ctl) begin
                bad++;
                $display("FAIL basic_ctl c=%0d got=%b exp=%b", c, {busy, done, aborted, fifo_rd, disp_en}, exp_ctl);
            end
            if (een[0]) begin
                total++;
                if (disp_instr[31:0] !== 32'h100 + 32'(c - 2)) begin
                    bad++;
                    $display("FAIL basic_instr0 c=%0d got=%h exp=%h", c, disp_instr[31:0], 32'h100 + 32'(c - 2));
                end
            end
            if (een[1]) begin
                total++;
                if (disp_instr[63:32] !== 32'h200 + 32'(c - 2)) begin
                    bad++;
                    $display("FAIL basic_instr1 c=%0d got=%h exp=%h", c, disp_instr[63:32], 32'h200 + 32'(c - 2));
                end
            end
        end
        total++;
        if (disp_count !== 16'd5) begin
            bad++;
            $display("FAIL basic_count got=%0d exp=5", disp_count);
        end
    endtask

    task automatic test_backpressure;
        logic [6:0] exp_ctl;
        logic       een;
        load_fifos(2, 0, 32'hA, 32'h0);
        disp_ack = 2'b10;
        start_seq(2'b11);
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            disp_ack[0] = (c >= 6);
            #1;
            een = (c >= 2 && c <= 7);
            exp_ctl = {c <= 7, c == 8, 1'b0, 1'b0, (c == 1 || c == 6), 1'b0, een};
            total++;
            if ({busy, done, aborted, fifo_rd, disp_en} !== exp_ctl) begin
                bad++;
                $display("FAIL bp_ctl c=%0d got=%b exp=%b", c, {busy, done, aborted, fifo_rd, disp_en}, exp_ctl);
            end
            if (een) begin
                total++;
                if (disp_instr[31:0] !== ((c <= 6) ? 32'hA : 32'hB)) begin
                    bad++;
                    $display("FAIL bp_instr c=%0d got=%h exp=%h", c, disp_instr[31:0], (c <= 6) ? 32'hA : 32'hB);
                end
            end
        end
        total++;
        if (disp_count !== 16'd2) begin
            bad++;
            $display("FAIL bp_count got=%0d exp=2", disp_count);
        end
    endtask

    task automatic test_mask;
        logic [6:0] exp_ctl;
        load_fifos(2, 2, 32'h10, 32'h20);
        disp_ack = 2'b11;
        start_seq(2'b01);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            exp_ctl = {c <= 3, c == 4, 1'b0, 1'b0, c <= 2, 1'b0, (c >= 2 && c <= 3)};
            total++;
            if ({busy, done, aborted, fifo_rd, disp_en} !== exp_ctl) begin
                bad++;
                $display("FAIL mask_ctl c=%0d got=%b exp=%b", c, {busy, done, aborted, fifo_rd, disp_en}, exp_ctl);
            end
        end
        total++;
        if (disp_count !== 16'd2) begin
            bad++;
            $display("FAIL mask_count got=%0d exp=2", disp_count);
        end
        total++;
        if (q1.size() !== 2) begin
            bad++;
            $display("FAIL mask_fifo1_left got=%0d exp=2", q1.size());
        end
    endtask

    task automatic test_abort;
        logic [6:0] exp_ctl;
        logic       een;
        load_fifos(10, 0, 32'h300, 32'h0);
        disp_ack = 2'b00;
        start_seq(2'b11);
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) @(negedge clk);
            abort       = (c == 3);
            disp_ack[0] = (c == 14);
            #1;
            een = (c >= 2 && c <= 14);
            exp_ctl = {c <= 14, 1'b0, c == 15, 1'b0, (c == 1 || (c >= 4 && c <= 12)), 1'b0, een};
            total++;
            if ({busy, done, aborted, fifo_rd, disp_en} !== exp_ctl) begin
                bad++;
                $display("FAIL abort_ctl c=%0d got=%b exp=%b", c, {busy, done, aborted, fifo_rd, disp_en}, exp_ctl);
            end
            if (een) begin
                total++;
                if (disp_instr[31:0] !== 32'h300) begin
                    bad++;
                    $display("FAIL abort_instr c=%0d got=%h exp=300", c, disp_instr[31:0]);
                end
            end
        end
        abort = 1'b0;
        total++;
        if (disp_count !== 16'd1 || q0.size() !== 0) begin
            bad++;
            $display("FAIL abort_count got count=%0d left=%0d exp count=1 left=0", disp_count, q0.size());
        end
    endtask

    task automatic test_saturation;
        int done_cyc;
        done_cyc = 0;
        load_fifos(10, 0, 32'h400, 32'h0);
        disp_ack = 2'b11;
        start_seq(2'b11);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (done && done_cyc == 0) done_cyc = c;
            if (c == 10) begin
                total++;
                if (disp_count !== 16'd8 || s_disp_count !== 3'd7) begin
                    bad++;
                    $display("FAIL sat_mid got=%0d/%0d exp=8/7", disp_count, s_disp_count);
                end
            end
        end
        total++;
        if (done_cyc !== 12) begin
            bad++;
            $display("FAIL sat_done_cycle got=%0d exp=12", done_cyc);
        end
        total++;
        if (disp_count !== 16'd10 || s_disp_count !== 3'd7) begin
            bad++;
            $display("FAIL sat_final got=%0d/%0d exp=10/7", disp_count, s_disp_count);
        end
    endtask

    task automatic test_reset_mid;
        logic [6:0] exp_ctl;
        load_fifos(5, 0, 32'h500, 32'h0);
        disp_ack = 2'b00;
        start_seq(2'b11);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (disp_en !== 2'b01 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rmid_pre got en=%b busy=%b exp en=01 busy=1", disp_en, busy);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({busy, fifo_rd, disp_en} !== 5'b0 || disp_instr !== 64'h0 || disp_count !== 16'h0) begin
            bad++;
            $display("FAIL rmid_async got ctl=%b instr=%h count=%0d exp 0", {busy, fifo_rd, disp_en}, disp_instr, disp_count);
        end
        @(negedge clk);
        rst = 1'b1;
        load_fifos(2, 0, 32'h600, 32'h0);
        disp_ack = 2'b11;
        start_seq(2'b01);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            exp_ctl = {c <= 3, c == 4, 1'b0, 1'b0, c <= 2, 1'b0, (c >= 2 && c <= 3)};
            total++;
            if ({busy, done, aborted, fifo_rd, disp_en} !== exp_ctl) begin
                bad++;
                $display("FAIL rmid_restart c=%0d got=%b exp=%b", c, {busy, done, aborted, fifo_rd, disp_en}, exp_ctl);
            end
            if (c == 3) begin
                total++;
                if (disp_instr[31:0] !== 32'h601) begin
                    bad++;
                    $display("FAIL rmid_instr got=%h exp=601", disp_instr[31:0]);
                end
            end
        end
        total++;
        if (disp_count !== 16'd2) begin
            bad++;
            $display("FAIL rmid_count got=%0d exp=2", disp_count);
        end
    endtask

    task automatic test_empty_start;
        logic [6:0] exp_ctl;
        load_fifos(0, 0, 32'h0, 32'h0);
        disp_ack = 2'b11;
        start_seq(2'b11);
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            exp_ctl = {c == 1, c == 2, 5'b00000};
            total++;
            if ({busy, done, aborted, fifo_rd, disp_en} !== exp_ctl) begin
                bad++;
                $display("FAIL empty_ctl c=%0d got=%b exp=%b", c, {busy, done, aborted, fifo_rd, disp_en}, exp_ctl);
            end
            if (c == 2) begin
                total++;
                if (disp_count !== 16'd0) begin
                    bad++;
                    $display("FAIL empty_count got=%0d exp=0", disp_count);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_mask();
        test_abort();
        test_saturation();
        test_reset_mid();
        test_empty_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
